// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//   Shares one single-port mock_ram between N_REQ requesters. Each requester
//   has a valid/ready request channel. At most one request is granted per
//   cycle. In-flight reads are tracked through a LATENCY-deep tag pipeline so
//   that ram dout is returned to the issuing requester with a resp_valid
//   pulse.
//
//   Configuration macro: RAM_ARB_FIXED_PRIO_EN
//     defined   -> fixed priority, the lowest-index valid requester wins and
//                  no pointer register exists
//     undefined -> round-robin with a last-granted pointer (default)
//
// Ports
//   clk          clock
//   rstn         asynchronous active-low reset
//   req_valid    [N_REQ]          request present, per requester
//   req_ready    [N_REQ]          request accepted this cycle (one-hot/zero)
//   req_write    [N_REQ]          1 = write, 0 = read
//   req_addr     [N_REQ*W_ADDR]   packed request addresses
//   req_wdata    [N_REQ*W_DATA]   packed write data
//   resp_valid   [N_REQ]          read data valid, per requester
//   resp_rdata   [W_DATA]         read data shared by all requesters
//   ram_write_en                  to mock_ram write_en
//   ram_addr     [W_ADDR]         to mock_ram addr
//   ram_din      [W_DATA]         to mock_ram din
//   ram_dout     [W_DATA]         from mock_ram dout
// ---------------------------------------------------------------------------
module ram_arbiter #(
    parameter int W_DATA  = 8,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1,
    parameter int N_REQ   = 2
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [N_REQ-1:0]                  req_valid,
    output logic [N_REQ-1:0]                  req_ready,
    input  logic [N_REQ-1:0]                  req_write,
    input  logic [N_REQ*$clog2(DEPTH)-1:0]    req_addr,
    input  logic [N_REQ*W_DATA-1:0]           req_wdata,
    output logic [N_REQ-1:0]                  resp_valid,
    output logic [W_DATA-1:0]                 resp_rdata,
    output logic                              ram_write_en,
    output logic [$clog2(DEPTH)-1:0]          ram_addr,
    output logic [W_DATA-1:0]                 ram_din,
    input  logic [W_DATA-1:0]                 ram_dout
);

    localparam int W_ADDR = $clog2(DEPTH);
    localparam int W_ID   = $clog2(N_REQ);

    logic              w_any;
    logic [W_ID-1:0]   w_gnt_id;
    logic              w_xfer;
    logic              w_rd_xfer;
    logic              w_sel_write;
    logic [W_ADDR-1:0] w_sel_addr;
    logic [W_DATA-1:0] w_sel_wdata;

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Fixed priority: scan from the top so the lowest valid index is the last write.
    always_comb begin
        w_any    = 1'b0;
        w_gnt_id = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_any    = 1'b1;
                w_gnt_id = W_ID'(i);
            end else begin
                w_any    = w_any;
            end
        end
    end
`else
    logic [W_ID-1:0] r_ptr;
    logic [W_ID-1:0] w_cand;

    // Round-robin: candidates ptr+N_REQ down to ptr+1, so the nearest one after
    // the pointer is the last assignment and wins.
    always_comb begin
        w_any    = 1'b0;
        w_gnt_id = '0;
        w_cand   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = W_ID'((int'(r_ptr) + k) % N_REQ);
            if (req_valid[w_cand]) begin
                w_any    = 1'b1;
                w_gnt_id = w_cand;
            end else begin
                w_any    = w_any;
            end
        end
    end

    // Last-granted pointer; reset to N_REQ-1 so requester 0 is searched first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= W_ID'(N_REQ - 1);
        end else if (w_xfer) begin
            r_ptr <= w_gnt_id;
        end else begin
            r_ptr <= r_ptr;
        end
    end
`endif

    // Gating with rstn keeps the request side and RAM side quiet while reset is held.
    assign w_xfer    = rstn & w_any;
    assign w_rd_xfer = w_xfer & ~w_sel_write;

    // Select the granted requester's write flag, address and data.
    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_id == W_ID'(i)) begin
                w_sel_write = req_write[i];
                w_sel_addr  = req_addr[i*W_ADDR +: W_ADDR];
                w_sel_wdata = req_wdata[i*W_DATA +: W_DATA];
            end else begin
                w_sel_write = w_sel_write;
            end
        end
    end

    // Ready is one-hot on the granted requester and zero when nothing transfers.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = w_xfer && (w_gnt_id == W_ID'(i));
        end
    end

    // RAM drive is zeroed whenever no transfer takes place.
    always_comb begin
        if (w_xfer) begin
            ram_write_en = w_sel_write;
            ram_addr     = w_sel_addr;
            ram_din      = w_sel_wdata;
        end else begin
            ram_write_en = 1'b0;
            ram_addr     = '0;
            ram_din      = '0;
        end
    end

    assign resp_rdata = ram_dout;

    generate
        if (LATENCY == 0) begin : g_lat0
            // Zero latency: the response is the read transfer itself.
            always_comb begin
                resp_valid = '0;
                if (w_rd_xfer) begin
                    resp_valid[w_gnt_id] = 1'b1;
                end else begin
                    resp_valid = '0;
                end
            end
        end else begin : g_pipe
            logic [LATENCY-1:0] r_tag_vld;
            logic [W_ID-1:0]    r_tag_id [LATENCY];

            // Tag shift register mirroring mock_ram's read delay; reset drops in-flight reads.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_tag_vld <= '0;
                    for (int i = 0; i < LATENCY; i++) begin
                        r_tag_id[i] <= '0;
                    end
                end else begin
                    r_tag_vld[0] <= w_rd_xfer;
                    r_tag_id[0]  <= w_gnt_id;
                    for (int i = 1; i < LATENCY; i++) begin
                        r_tag_vld[i] <= r_tag_vld[i-1];
                        r_tag_id[i]  <= r_tag_id[i-1];
                    end
                end
            end

            // Decode the tag leaving the pipeline into a per-requester pulse.
            always_comb begin
                resp_valid = '0;
                if (r_tag_vld[LATENCY-1]) begin
                    resp_valid[r_tag_id[LATENCY-1]] = 1'b1;
                end else begin
                    resp_valid = '0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
//   Three ram_arbiter instances (LATENCY 1, 3, 0; N_REQ 2) each attached to a
//   behavioural mock_ram. Directed stimulus pushes expected responses into a
//   scoreboard; a monitor pops and compares whenever resp_valid is seen.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

    logic       clk;
    logic       rstn;
    logic [1:0] req_valid  [3];
    logic [1:0] req_ready  [3];
    logic [1:0] req_write  [3];
    logic [15:0] req_addr  [3];
    logic [15:0] req_wdata [3];
    logic [1:0] resp_valid [3];
    logic [7:0] resp_rdata [3];
    logic       ram_we     [3];
    logic [7:0] ram_addr   [3];
    logic [7:0] ram_din    [3];
    logic [7:0] ram_dout   [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         inst;
        int         id;
        logic [7:0] data;
        int         due;
    } exp_t;
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_inst
            localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
            logic [7:0] mem [256];

            ram_arbiter #(
                .W_DATA (8),
                .DEPTH  (256),
                .LATENCY(L),
                .N_REQ  (2)
            ) u_dut (
                .clk         (clk),
                .rstn        (rstn),
                .req_valid   (req_valid[g]),
                .req_ready   (req_ready[g]),
                .req_write   (req_write[g]),
                .req_addr    (req_addr[g]),
                .req_wdata   (req_wdata[g]),
                .resp_valid  (resp_valid[g]),
                .resp_rdata  (resp_rdata[g]),
                .ram_write_en(ram_we[g]),
                .ram_addr    (ram_addr[g]),
                .ram_din     (ram_din[g]),
                .ram_dout    (ram_dout[g])
            );

            always @(posedge clk) begin
                if (ram_we[g]) mem[ram_addr[g]] <= ram_din[g];
            end

            if (L == 0) begin : g_ram0
                assign ram_dout[g] = mem[ram_addr[g]];
            end else begin : g_ramn
                logic [7:0] st [L];
                always @(posedge clk) begin
                    st[0] <= ram_we[g] ? ram_din[g] : mem[ram_addr[g]];
                    for (int i = 1; i < L; i++) st[i] <= st[i-1];
                end
                assign ram_dout[g] = st[L-1];
            end
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int inst, input logic [1:0] v, input logic [1:0] w,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1);
        req_valid[inst] = v;
        req_write[inst] = w;
        req_addr[inst]  = {a1, a0};
        req_wdata[inst] = {d1, d0};
    endtask

    task automatic expect_rsp(input int inst, input int id, input logic [7:0] data, input int lat);
        exp_t e;
        e.inst = inst;
        e.id   = id;
        e.data = data;
        e.due  = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every response, flag overdue expectations.
    always @(negedge clk) begin
        int f;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid[i] != 2'b00) begin
                f = -1;
                for (int j = 0; j < sb.size(); j++) begin
                    if (f < 0 && sb[j].inst == i) f = j;
                end
                if (f < 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp inst%0d: got resp_valid=%b, expected none (cycle %0d)",
                             i, resp_valid[i], cyc);
                end else begin
                    chk($sformatf("resp_cycle inst%0d", i), cyc, sb[f].due);
                    chk($sformatf("resp_valid inst%0d", i), resp_valid[i], 32'(2'b01 << sb[f].id));
                    chk($sformatf("resp_rdata inst%0d", i), resp_rdata[i], sb[f].data);
                    sb.delete(f);
                end
            end
        end
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_resp inst%0d: got no response, expected id %0d data %0h at cycle %0d",
                         sb[j].inst, sb[j].id, sb[j].data, sb[j].due);
                sb.delete(j);
            end
        end
    end

    initial begin
        int gi;
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) drive(i, 2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
        tick();
        // Reset state with requests pending: nothing may be granted or driven.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ready inst%0d", i), req_ready[i], 2'b00);
            chk($sformatf("rst_we inst%0d", i), ram_we[i], 1'b0);
            chk($sformatf("rst_addr inst%0d", i), ram_addr[i], 8'h00);
            chk($sformatf("rst_din inst%0d", i), ram_din[i], 8'h00);
            chk($sformatf("rst_resp inst%0d", i), resp_valid[i], 2'b00);
        end
        for (int i = 0; i < 3; i++) drive(i, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        rstn = 1'b1;
        tick();

        // LATENCY=1: write 0x10=A5 then read it back next cycle.
        drive(0, 2'b01, 2'b01, 8'h10, 8'h00, 8'hA5, 8'h00);
        @(negedge clk);
        chk("wr_ready", req_ready[0], 2'b01);
        chk("wr_we", ram_we[0], 1'b1);
        chk("wr_addr", ram_addr[0], 8'h10);
        chk("wr_din", ram_din[0], 8'hA5);
        tick();
        drive(0, 2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00);
        expect_rsp(0, 0, 8'hA5, 1);
        @(negedge clk);
        chk("rd_ready", req_ready[0], 2'b01);
        chk("rd_we", ram_we[0], 1'b0);
        tick();
        drive(0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        chk("idle_ready", req_ready[0], 2'b00);
        chk("idle_addr", ram_addr[0], 8'h00);
        tick();

        // Preload 0x01=11 (req0) and 0x02=22 (req1), then contend for 4 cycles.
        drive(0, 2'b01, 2'b01, 8'h01, 8'h00, 8'h11, 8'h00);
        tick();
        drive(0, 2'b10, 2'b10, 8'h00, 8'h02, 8'h00, 8'h22);
        @(negedge clk);
        chk("pre_ready1", req_ready[0], 2'b10);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(0, 2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
`ifdef RAM_ARB_FIXED_PRIO_EN
            gi = 0;
`else
            gi = k % 2;
`endif
            expect_rsp(0, gi, (gi == 0) ? 8'h11 : 8'h22, 1);
            @(negedge clk);
            chk($sformatf("arb_ready k%0d", k), req_ready[0], 32'(2'b01 << gi));
            tick();
        end
        drive(0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (2) tick();

        // LATENCY=3: preload 0x20..0x22 via req1, then three back-to-back reads.
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b10, 2'b10, 8'h00, 8'(8'h20 + i), 8'h00, 8'(8'h31 + i));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b10, 2'b00, 8'h00, 8'(8'h20 + i), 8'h00, 8'h00);
            expect_rsp(1, 1, 8'(8'h31 + i), 3);
            @(negedge clk);
            chk($sformatf("l3_ready i%0d", i), req_ready[1], 2'b10);
            tick();
        end
        drive(1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (4) tick();

        // Reads in flight, then a one-cycle reset: they must be discarded.
        drive(1, 2'b11, 2'b00, 8'h20, 8'h21, 8'h00, 8'h00);
        repeat (2) tick();
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_ready", req_ready[1], 2'b00);
        chk("midrst_resp", resp_valid[1], 2'b00);
        tick();
        rstn = 1'b1;
        drive(1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (4) tick();
        drive(1, 2'b11, 2'b00, 8'h20, 8'h21, 8'h00, 8'h00);
        expect_rsp(1, 0, 8'h31, 3);
        @(negedge clk);
        chk("postrst_ready", req_ready[1], 2'b01);
        tick();
        drive(1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (4) tick();

        // LATENCY=0: preload 0x05=5A, read returns in the same cycle.
        drive(2, 2'b01, 2'b01, 8'h05, 8'h00, 8'h5A, 8'h00);
        tick();
        drive(2, 2'b01, 2'b00, 8'h05, 8'h00, 8'h00, 8'h00);
        expect_rsp(2, 0, 8'h5A, 0);
        @(negedge clk);
        chk("l0_ready", req_ready[2], 2'b01);
        tick();
        drive(2, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) tick();

        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
